// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 matrix keypad scanner.
//   kp_state_t  - scanner FSM states.
//   row_hit_t   - result of decoding one synchronized row sample.
//   KEY_MAP     - hex code of each key, indexed [row][col].
//   onehot0_low - flags a sample with exactly one active-low row bit and
//                 reports the index of that bit.
//   col_drive   - active-low column drive pattern for a column index.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } row_hit_t;

    // Pmod KYPD legend. Row 3 is the bottom row: 0 F E D.
    localparam logic [3:0] KEY_MAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    // Exactly one low bit is a clean press. No low bit is idle; two or more
    // low bits on one column is ambiguous (ghosting) and is treated as idle.
    function automatic row_hit_t onehot0_low(input logic [3:0] rows);
        row_hit_t   res;
        logic [2:0] zeros;
        res   = '0;
        zeros = '0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) begin
                zeros   = zeros + 3'd1;
                res.idx = 2'(i);
            end
        end
        res.hit = (zeros == 3'd1);
        return res;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff: two-flop synchronizer for the keypad row lines.
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset; output resets to all ones, the
//           idle (pulled-up) state of the rows, so no phantom press is seen
//   d     - asynchronous input
//   q     - synchronized output, two cycles behind d
module sync_2ff (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: time-multiplexed 4x4 matrix keypad scanner.
// Drives one column low at a time, samples the rows once at the end of each
// column window, debounces presses and releases, and reports a hex key code.
//   CLK100MHZ - system clock
//   reset     - asynchronous active-low reset
//   ROW       - keypad rows, active-low, asynchronous to the clock
//   COL       - column drive, active-low, exactly one bit low
//   key_code  - hex code of the last accepted key (held until the next one)
//   key_valid - one-cycle strobe when a new key is accepted
//   key_held  - high while the accepted key stays pressed
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int COL_TICKS  = 100_000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = $clog2(COL_TICKS);
    localparam int CW = $clog2(DEBOUNCE_N + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(COL_TICKS - 1);
    // The count already holds the samples seen so far, so the sample that
    // arrives while it equals N-1 is the N-th one.
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_N - 1);

    logic [3:0]    row_sync;
    logic [TW-1:0] tick;
    logic          sample;
    row_hit_t      rh;
    kp_state_t     state;
    logic [1:0]    col_idx;
    logic [1:0]    cap_row;
    logic [CW-1:0] cnt;

    sync_2ff u_sync (
        .clk   (CLK100MHZ),
        .rst_n (reset),
        .d     (ROW),
        .q     (row_sync)
    );

    // Free-running column window. Sampling on the last tick leaves the rest
    // of the window for the column change to settle through the synchronizer.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            tick <= '0;
        end else if (tick == TICK_LAST) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign sample = (tick == TICK_LAST);
    assign rh     = onehot0_low(row_sync);

    // Column only moves on a sample edge, and only when the FSM lets go of it
    // (no hit in SCAN, failed debounce, or a debounced release).
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            COL       <= 4'b1110;
            cap_row   <= 2'd0;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (rh.hit) begin
                            cap_row <= rh.idx;
                            cnt     <= CW'(1);
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            COL     <= col_drive(col_idx + 2'd1);
                        end
                    end
                    DEBOUNCE: begin
                        if (rh.hit && (rh.idx == cap_row)) begin
                            if (cnt == CNT_LAST) begin
                                key_code  <= KEY_MAP[cap_row][col_idx];
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                                state     <= HELD;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_idx + 2'd1;
                            COL     <= col_drive(col_idx + 2'd1);
                        end
                    end
                    HELD: begin
                        // Count consecutive release samples; any contact,
                        // even on another row, restarts the release count.
                        if (rh.hit) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            key_held <= 1'b0;
                            cnt      <= '0;
                            state    <= SCAN;
                            col_idx  <= col_idx + 2'd1;
                            COL      <= col_drive(col_idx + 2'd1);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner. Each stimulus that should
// yield a key event pushes the code (derived from the printed keypad legend)
// into a queue; an independent monitor pops and compares on every key_valid.
module tb_keypad_scanner;

    localparam int CT = 4;
    localparam int DN = 3;

    logic            clk;
    logic            rst_n;
    logic [3:0]      row;
    logic [3:0]      col;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_held;
    logic [3:0][3:0] pressed;   // [row][col] switch closed

    int         n_cmp;
    int         n_bad;
    logic [3:0] exp_q[$];
    logic [3:0] exp_code;
    logic       prev_valid;
    logic [3:0] mon_e;
    string      keymap = "123A456B789C0FED";

    keypad_scanner #(.COL_TICKS(CT), .DEBOUNCE_N(DN)) dut (
        .CLK100MHZ (clk),
        .reset     (rst_n),
        .ROW       (row),
        .COL       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a row reads low when a closed switch joins it to a
    // column currently driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r] & ~col);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_code(input int r, input int c);
        int ch;
        ch = int'(keymap.getc(r * 4 + c));
        if (ch >= 65) return 4'(ch - 55);
        return 4'(ch - 48);
    endfunction

    // Monitor: runs on the falling edge, independent of the stimulus.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_code   = 4'h0;
            prev_valid = 1'b0;
        end else begin
            check("col_single_low", $countones(~col), 1);
            if (key_valid) begin
                check("valid_one_cycle", {31'b0, prev_valid}, 0);
                check("held_with_valid", {31'b0, key_held}, 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_key_valid: got code %0h, expected no event (t=%0t)", key_code, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("key_code", key_code, mon_e);
                    exp_code = mon_e;
                end
            end else begin
                check("code_stable", key_code, exp_code);
            end
            prev_valid = key_valid;
        end
    end

    // Stimulus steps land 1 ns after the falling edge, after the monitor.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input int r, input int c);
        pressed[r][c] = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        check({name, "_event"}, exp_q.size(), 0);
        check({name, "_lat_min"}, {31'b0, n >= (DN - 1) * CT}, 1);
        check({name, "_lat_max"}, {31'b0, n <= (DN + 3) * CT + 3}, 1);
    endtask

    task automatic wait_fall(input string name);
        int n;
        n = 0;
        while (key_held && n < 25) begin
            tick(1);
            n++;
        end
        check({name, "_fall"}, {31'b0, key_held}, 0);
        check({name, "_fall_min"}, {31'b0, n >= (DN - 1) * CT}, 1);
    endtask

    task automatic wait_col(input logic [3:0] want);
        int n;
        n = 0;
        while (col !== want && n < 20) begin
            tick(1);
            n++;
        end
        check("wait_col", col, want);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_col"}, col, 4'b1110);
        check({name, "_code"}, key_code, 4'h0);
        check({name, "_valid"}, {31'b0, key_valid}, 0);
        check({name, "_held"}, {31'b0, key_held}, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_code = 4'h0;
        prev_valid = 1'b0;
        pressed = '0;
        rst_n = 1'b0;
        tick(3);
        check_reset_outputs("reset");

        // Idle scan: one column step every CT cycles after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            logic [3:0] e;
            tick(1);
            e = 4'hF;
            e[(k / CT) % 4] = 1'b0;
            check("idle_scan_col", col, e);
        end

        // r1/c2 press and hold: one event, column frozen.
        press(1, 2);
        exp_q.push_back(ref_code(1, 2));
        wait_drain("r1c2");
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("r1c2_held", {31'b0, key_held}, 1);
            check("r1c2_col_frozen", col, 4'b1011);
        end
        pressed = '0;
        wait_fall("r1c2");
        tick(10);

        // Bounce on r3/c0: a single-sample contact, then a stable press.
        wait_col(4'b0111);
        wait_col(4'b1110);
        press(3, 0);
        tick(4);
        pressed = '0;
        tick(6);
        press(3, 0);
        exp_q.push_back(ref_code(3, 0));
        wait_drain("bounce");
        pressed = '0;
        wait_fall("bounce");
        tick(10);

        // Ghosting on column 3: no event, scanning continues.
        begin
            int changes;
            logic [3:0] pc;
            press(0, 3);
            press(2, 3);
            changes = 0;
            pc = col;
            for (int i = 0; i < 40; i++) begin
                tick(1);
                if (col != pc) changes++;
                pc = col;
            end
            check("ghost_scan_moves", {31'b0, changes >= 8}, 1);
            pressed = '0;
            tick(20);
        end

        // Release of held 'D', scan resumes at column 0, then key '1'.
        press(3, 3);
        exp_q.push_back(ref_code(3, 3));
        wait_drain("key_d");
        tick(5);
        pressed = '0;
        wait_fall("key_d");
        check("resume_col", col, 4'b1110);
        press(0, 0);
        exp_q.push_back(ref_code(0, 0));
        wait_drain("key_1");
        pressed = '0;
        wait_fall("key_1");
        tick(10);

        // Asynchronous reset while HELD.
        press(2, 1);
        exp_q.push_back(ref_code(2, 1));
        wait_drain("pre_reset");
        tick(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        pressed = '0;
        tick(3);
        rst_n = 1'b1;
        tick(40);

        // Randomized presses, bounces and ghosts.
        for (int it = 0; it < 40; it++) begin
            int kind;
            int r;
            int c;
            kind = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            if (kind <= 1) begin
                press(r, c);
                exp_q.push_back(ref_code(r, c));
                tick($urandom_range(32, 60));
                check("rand_event", exp_q.size(), 0);
                check("rand_held", {31'b0, key_held}, 1);
                pressed = '0;
                wait_fall("rand");
                tick($urandom_range(5, 15));
            end else if (kind == 2) begin
                press(r, c);
                tick($urandom_range(1, 4));
                pressed = '0;
                tick(20);
            end else begin
                press(r, c);
                press((r + $urandom_range(1, 3)) % 4, c);
                tick($urandom_range(30, 50));
                pressed = '0;
                tick(20);
            end
        end

        tick(10);
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
